mux_arb_stream: RTL

MUX_ARB_STREAM -- requirements
Module: mux_arb_stream

---
 rtl/mux_arb_stream.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mux_arb_stream.sv
// N-channel stream multiplexer with a registered output stage, round-robin or
// fixed-priority arbitration, and a packet lock that keeps a multi-beat packet contiguous.
module mux_arb_stream #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = 2,
  parameter int MODE  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [SELW-1:0]    out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [SELW-1:0]   ptr_r;
  logic [SELW-1:0]   lock_ch_r;
  logic [SELW-1:0]   start_s;
  logic [SELW-1:0]   grant_s;
  logic [SELW:0]     pick_s;
  logic              grant_valid_s;
  logic              ld_s;
  logic              accept_s;
  logic              grant_last_s;
  logic [WIDTH-1:0]  grant_data_s;

  // First valid channel scanning start, start+1, ..., wrapping; MSB flags "found".
  function automatic logic [SELW:0] pick_first(input logic [N-1:0] valid,
                                               input logic [SELW-1:0] start);
    logic [SELW:0] res;
    int            idx;
    res = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(start) + (N - 1 - k);
      if (idx >= N) idx = idx - N;
      if (valid[SELW'(idx)]) res = {1'b1, SELW'(idx)};
    end
    return res;
  endfunction

  // Grant selection, load enable and the one-hot ready vector.
  always_comb begin
    ld_s    = !out_valid || out_ready;
    start_s = (MODE == 1) ? '0 : ptr_r;
    pick_s  = pick_first(in_valid, start_s);
    if (state_r == LOCKED) begin
      grant_s       = lock_ch_r;
      grant_valid_s = in_valid[lock_ch_r];
    end else begin
      grant_s       = pick_s[SELW-1:0];
      grant_valid_s = pick_s[SELW];
    end
    accept_s     = ld_s && grant_valid_s && !reset;
    grant_last_s = in_last[grant_s];
    grant_data_s = in_data[grant_s*WIDTH +: WIDTH];
    in_ready     = '0;
    if (accept_s) begin
      in_ready[grant_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Packet lock next state: a non-last beat locks, the last beat of the packet releases.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !grant_last_s) state_nxt_s = LOCKED;
        else                           state_nxt_s = IDLE;
      end
      LOCKED: begin
        if (accept_s && grant_last_s) state_nxt_s = IDLE;
        else                          state_nxt_s = LOCKED;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Packet lock state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Output register stage, locked channel and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
      lock_ch_r <= '0;
      ptr_r     <= '0;
    end else begin
      if (ld_s) begin
        out_valid <= grant_valid_s;
        if (grant_valid_s) begin
          out_data <= grant_data_s;
          out_last <= grant_last_s;
          out_sel  <= grant_s;
        end
      end
      if (accept_s && state_r == IDLE && !grant_last_s) lock_ch_r <= grant_s;
      if (MODE == 0 && accept_s && grant_last_s)
        ptr_r <= (grant_s == SELW'(N - 1)) ? '0 : grant_s + SELW'(1);
    end
  end

endmodule
